pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Owns the architectural PC of the single-cycle MIPS core and sequences instruction fetch.
//   Holds PC in a register and drives instruction memory with a fetch request.
//   Waits on memory-ready and stall, selects the next PC (PC+4 / branch / jump / jr) and stops on halt.
//   Sits between the PC+4 adder/branch logic and the instruction memory.
// PARAMETERS
//   RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//   TRAP_VECTOR   32'h0000_0080  PC loaded on misaligned target (MISALIGN_TRAP_EN only)
// PORTS
//   clk            in   1   system clock, rising edge
//   rst_n          in   1   asynchronous reset, active-low
//   imem_ready     in   1   instruction word for PC_out is valid this cycle
//   stall          in   1   hold PC; no commit this cycle
//   halt           in   1   decoded halt instruction in current word
//   jr             in   1   jump-register selected
//   jr_target      in   32  rs value for jr
//   jump           in   1   j/jal selected
//   jump_target    in   32  {PC+4[31:28], imm26, 2'b00}
//   branch_taken   in   1   beq/bne condition true
//   branch_target  in   32  PC+4 + (sext(imm16)<<2)
//   PC_out         out  32  current PC (instruction memory address)
//   PC_plus4       out  32  PC_out + 4, modulo 2^32
//   fetch_req      out  1   instruction memory read request
//   instr_valid    out  1   current instruction commits this cycle
//   halted         out  1   core stopped
//   retired_count  out  32  committed-instruction counter
// BEHAVIOUR
//   Reset (rst_n=0, async): state=BOOT, PC_out=RESET_VECTOR, retired_count=0.
//     Also fetch_req=0, instr_valid=0, halted=0 (trap=0, epc=0 with macro).
//   FSM states: BOOT, FETCH, HALTED.
//     BOOT   -> FETCH unconditionally after 1 clk; fetch_req=0.
//     FETCH  fetch_req=1; commit = imem_ready & ~stall.
//            commit: instr_valid=1 (combinational, same cycle); PC_out<=next_pc; retired_count+=1.
//            no commit: PC_out and counter hold; instr_valid=0.
//            commit & halt -> HALTED; PC_out holds (not advanced); retired_count+=1.
//     HALTED fetch_req=0, instr_valid=0, halted=1; stays until rst_n=0.
//   next_pc priority (several selects high at once): halt > jr > jump > branch_taken > PC_plus4.
//   Selects are ignored when no commit occurs (stall or !imem_ready).
//   Wrap: PC 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
//   retired_count wraps at 2^32.
//   Reset mid-stall or mid-HALTED returns to BOOT immediately; pending selects are discarded.
//   Latency: new PC visible on PC_out 1 clk after committing edge; zero bubbles between commits.
// CONFIGURATION
//   MISALIGN_TRAP_EN undefined:
//     selected jr/jump/branch target has bits[1:0] forced to 2'b00; no trap logic.
//   MISALIGN_TRAP_EN defined:
//     adds ports trap (out 1) and epc (out 32).
//     On commit with selected target[1:0]!=0: PC_out<=TRAP_VECTOR, epc<=PC_out of faulting instr.
//     trap=1 for exactly the clk following that commit; halt still has priority over trap.
// TESTING
//   1 Reset release, imem_ready=1 always -> BOOT 1 clk (fetch_req=0).
//     Then PC_out 0x0,0x4,0x8 on consecutive clks; retired_count=3 after 3 commits.
//   2 PC=0x10, stall=1 for 3 clks with branch_taken=1, branch_target=0x40.
//     -> PC holds 0x10, instr_valid=0; stall drops -> PC=0x40 next clk.
//   3 PC=0x20, jr=1 jr_target=0x100, jump=1 jump_target=0x200, branch_taken=1 same cycle
//     -> PC=0x100.
//   4 PC=0x30, halt=1 with imem_ready=1 -> halted=1, PC stays 0x30, fetch_req=0.
//     Further inputs ignored until rst_n=0.
//   5 PC=0xFFFF_FFFC, no selects -> PC=0x0; imem_ready=0 for 2 clks -> PC holds, counter holds.
//   6 jump_target=0x202 at PC=0x8.
//     Without macro -> PC=0x200.
//     With MISALIGN_TRAP_EN -> PC=0x80, epc=0x8, trap pulse 1 clk.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - architectural PC register and fetch sequencer (optional MISALIGN_TRAP_EN)
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef MISALIGN_TRAP_EN
    ,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        halt,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] PC_out,
    output logic [31:0] PC_plus4,
    output logic        fetch_req,
    output logic        instr_valid,
    output logic        halted,
    output logic [31:0] retired_count
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        trap,
    output logic [31:0] epc
`endif
);

    typedef enum logic [1:0] {BOOT, FETCH, HALTED} state_t;

    state_t      state;
    logic        commit;
    logic        target_sel;
    logic [31:0] sel_target;
    logic [31:0] next_pc;
    logic        misaligned;

    assign PC_plus4    = PC_out + 32'd4;
    assign commit      = (state == FETCH) & imem_ready & ~stall;
    assign instr_valid = commit;

    // Priority among redirects: jr > jump > branch; halt is handled in the FSM.
    always_comb begin
        target_sel = jr | jump | branch_taken;
        if (jr)
            sel_target = jr_target;
        else if (jump)
            sel_target = jump_target;
        else if (branch_taken)
            sel_target = branch_target;
        else
            sel_target = PC_plus4;
    end

`ifdef MISALIGN_TRAP_EN
    assign misaligned = target_sel & (|sel_target[1:0]);
    assign next_pc    = target_sel ? sel_target : PC_plus4;
`else
    assign misaligned = 1'b0;
    assign next_pc    = target_sel ? (sel_target & 32'hFFFF_FFFC) : PC_plus4;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT;
            PC_out        <= RESET_VECTOR;
            retired_count <= 32'd0;
            fetch_req     <= 1'b0;
            halted        <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            trap          <= 1'b0;
            epc           <= 32'd0;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
            trap <= 1'b0;
`endif
            case (state)
                BOOT: begin
                    state     <= FETCH;
                    fetch_req <= 1'b1;
                end
                FETCH: begin
                    if (commit) begin
                        retired_count <= retired_count + 32'd1;
                        if (halt) begin
                            state     <= HALTED;
                            fetch_req <= 1'b0;
                            halted    <= 1'b1;
                        end else if (misaligned) begin
`ifdef MISALIGN_TRAP_EN
                            PC_out <= TRAP_VECTOR;
                            epc    <= PC_out;
                            trap   <= 1'b1;
`endif
                        end else begin
                            PC_out <= next_pc;
                        end
                    end
                end
                HALTED: begin
                    fetch_req <= 1'b0;
                    halted    <= 1'b1;
                end
                default: begin
                    state     <= BOOT;
                    fetch_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed plus randomized checks of pc_sequencer against a fetch model
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ready = 1'b0, stall = 1'b0, halt = 1'b0;
    logic        jr = 1'b0, jump = 1'b0, branch_taken = 1'b0;
    logic [31:0] jr_target = '0, jump_target = '0, branch_target = '0;
    logic [31:0] PC_out, PC_plus4, retired_count;
    logic        fetch_req, instr_valid, halted;
`ifdef MISALIGN_TRAP_EN
    logic        trap;
    logic [31:0] epc;
`endif

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .stall(stall), .halt(halt),
        .jr(jr), .jr_target(jr_target), .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .PC_out(PC_out), .PC_plus4(PC_plus4), .fetch_req(fetch_req),
        .instr_valid(instr_valid), .halted(halted), .retired_count(retired_count)
`ifdef MISALIGN_TRAP_EN
        , .trap(trap), .epc(epc)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what the core should look like to the outside world.
    logic [31:0] m_pc = RV, m_cnt = '0, m_epc = '0;
    bit          m_booted = 0, m_halted = 0, m_trap = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit ir, input bit st, input bit hl,
                         input bit j_r, input logic [31:0] jrt,
                         input bit jp, input logic [31:0] jpt,
                         input bit br, input logic [31:0] brt);
        bit          cm;
        logic [31:0] tgt;
        @(negedge clk);
        imem_ready = ir; stall = st; halt = hl;
        jr = j_r; jr_target = jrt; jump = jp; jump_target = jpt;
        branch_taken = br; branch_target = brt;
        #1;
        cm = m_booted && !m_halted && ir && !st;
        check("pc", PC_out, m_pc);
        check("pc_plus4", PC_plus4, m_pc + 32'd4);
        check("fetch_req", {31'd0, fetch_req}, {31'd0, m_booted && !m_halted});
        check("instr_valid", {31'd0, instr_valid}, {31'd0, cm});
        check("halted", {31'd0, halted}, {31'd0, m_halted});
        check("retired", retired_count, m_cnt);
`ifdef MISALIGN_TRAP_EN
        check("trap", {31'd0, trap}, {31'd0, m_trap});
        check("epc", epc, m_epc);
`endif
        @(posedge clk);
        m_trap = 0;
        if (!m_booted) begin
            m_booted = 1;
        end else if (cm) begin
            m_cnt = m_cnt + 32'd1;
            if (hl) begin
                m_halted = 1;
            end else if (!(j_r || jp || br)) begin
                m_pc = m_pc + 32'd4;
            end else begin
                tgt = j_r ? jrt : (jp ? jpt : brt);
`ifdef MISALIGN_TRAP_EN
                if (tgt[1:0] != 2'b00) begin
                    m_epc = m_pc; m_pc = TV; m_trap = 1;
                end else
`endif
                m_pc = {tgt[31:2], 2'b00};
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_pc", PC_out, RV);
        check("rst_retired", retired_count, 32'd0);
        check("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_pc = RV; m_cnt = '0; m_epc = '0;
        m_booted = 0; m_halted = 0; m_trap = 0;
    endtask

    task automatic plain(input bit ir, input bit st);
        cycle(ir, st, 0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic goto(input logic [31:0] a);
        cycle(1, 0, 0, 0, '0, 1, a, 0, '0);
    endtask

    initial begin
        bit ir, st, hl, j_r, jp, br;
        // Test 1: boot bubble then sequential fetch
        do_reset();
        plain(1, 0);
        plain(1, 0); plain(1, 0); plain(1, 0);
        #1 check("t1_pc", PC_out, 32'h0000_000C);
        check("t1_retired", retired_count, 32'd3);

        // Test 2: stalled branch is ignored until the stall drops
        goto(32'h10);
        repeat (3) cycle(1, 1, 0, 0, '0, 0, '0, 1, 32'h40);
        cycle(1, 0, 0, 0, '0, 0, '0, 1, 32'h40);
        #1 check("t2_pc", PC_out, 32'h40);

        // Test 3: jr wins over jump and branch
        goto(32'h20);
        cycle(1, 0, 0, 1, 32'h100, 1, 32'h200, 1, 32'h300);
        #1 check("t3_pc", PC_out, 32'h100);

        // Test 5: wrap and imem not ready
        goto(32'hFFFF_FFFC);
        plain(1, 0);
        #1 check("t5_wrap", PC_out, 32'h0);
        plain(0, 0); plain(0, 0);

        // Test 6: misaligned jump target
        goto(32'h8);
        cycle(1, 0, 0, 0, '0, 1, 32'h202, 0, '0);
`ifdef MISALIGN_TRAP_EN
        #1 check("t6_pc", PC_out, 32'h80);
        check("t6_epc", epc, 32'h8);
        check("t6_trap", {31'd0, trap}, 32'd1);
`else
        #1 check("t6_pc", PC_out, 32'h200);
`endif
        plain(1, 0);

        // Test 4: halt beats every redirect and freezes the core
        goto(32'h30);
        cycle(1, 0, 1, 1, 32'h500, 1, 32'h600, 1, 32'h700);
        #1 check("t4_pc", PC_out, 32'h30);
        check("t4_halted", {31'd0, halted}, 32'd1);
        repeat (3) cycle(1, 0, 0, 0, '0, 1, 32'h44, 1, 32'h48);
        do_reset();
        plain(1, 0);

        // Randomized traffic, including resets while stalled or halted
        for (int i = 0; i < 400; i++) begin
            if (m_halted && $urandom_range(0, 5) == 0) do_reset();
            else if ($urandom_range(0, 99) == 0) do_reset();
            ir  = $urandom_range(0, 3) != 0;
            st  = $urandom_range(0, 3) == 0;
            hl  = $urandom_range(0, 31) == 0;
            j_r = $urandom_range(0, 5) == 0;
            jp  = $urandom_range(0, 5) == 0;
            br  = $urandom_range(0, 3) == 0;
            cycle(ir, st, hl, j_r, $urandom, jp, $urandom, br,
                  ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
